note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_seq_pkg.sv | 44 ++++
 rtl/note_sequencer_song_rom.sv | 47 ++++
 rtl/note_sequencer.sv | 161 ++++++++++++++++
 tb/tb_note_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states, ROM word
// layout, special frequency codes and a few concert-pitch note values.
package note_seq_pkg;

  localparam int FREQ_W = 16;
  localparam int DUR_W  = 4;
  localparam int WORD_W = FREQ_W + DUR_W;

  localparam logic [FREQ_W-1:0] FREQ_OFF     = 16'd0;
  localparam logic [FREQ_W-1:0] FREQ_SILENCE = 16'd1;

  localparam logic [FREQ_W-1:0] NOTE_C4 = 16'd262;
  localparam logic [FREQ_W-1:0] NOTE_D4 = 16'd294;
  localparam logic [FREQ_W-1:0] NOTE_E4 = 16'd330;
  localparam logic [FREQ_W-1:0] NOTE_A4 = 16'd440;
  localparam logic [FREQ_W-1:0] NOTE_B4 = 16'd494;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    PAUSE
  } state_t;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

  function automatic rom_word_t make_note(input logic [FREQ_W-1:0] f,
                                          input logic [DUR_W-1:0]  d);
    rom_word_t w;
    w.freq = f;
    w.dur  = d;
    return w;
  endfunction

  // States in which the sequencer counts as actively playing a song.
  function automatic logic is_active(input state_t s);
    return (s == FETCH) || (s == PLAY) || (s == GAP);
  endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// Song ROM with combinational read. SONG selects between built-in tunes;
// every address past the last note reads as the end marker (dur == 0).
module song_rom
  import note_seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int SONG   = 0
) (
  input  logic [ADDR_W-1:0] addr,
  output rom_word_t         word
);

  function automatic rom_word_t song_entry(input int song, input int idx);
    rom_word_t w;
    w = make_note(FREQ_OFF, 4'd0);
    if (song == 0) begin
      case (idx)
        0:       w = make_note(NOTE_A4, 4'd2);
        1:       w = make_note(NOTE_B4, 4'd1);
        default: w = make_note(FREQ_OFF, 4'd0);
      endcase
    end else begin
      // Exercises both rest codes; sized so a 4-entry ROM has no end marker.
      case (idx)
        0:       w = make_note(NOTE_C4, 4'd1);
        1:       w = make_note(FREQ_OFF, 4'd1);
        2:       w = make_note(NOTE_E4, 4'd2);
        3:       w = make_note(FREQ_SILENCE, 4'd1);
        4:       w = make_note(NOTE_D4, 4'd2);
        default: w = make_note(FREQ_OFF, 4'd0);
      endcase
    end
    return w;
  endfunction

  rom_word_t rom_tbl [2**ADDR_W];

  genvar gi;
  generate
    for (gi = 0; gi < 2**ADDR_W; gi++) begin : g_rom
      assign rom_tbl[gi] = song_entry(SONG, gi);
    end
  endgenerate

  assign word = rom_tbl[addr];

endmodule

// File: rtl/note_sequencer.sv
// Plays a song from ROM one note per duration of beats, with a play/pause
// pushbutton, optional inter-note gap and optional looping.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter bit LOOP   = 1'b1,
  parameter bit GAP_EN = 1'b1,
  parameter int SONG   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boton,
  input  logic              tick,
  output logic [FREQ_W-1:0] freq_out,
  output logic [ADDR_W-1:0] note_idx,
  output logic              playing,
  output logic              note_strobe,
  output logic              song_end
);

  logic sync1_reg, sync2_reg, sync3_reg;
  logic toggle;

  state_t            state_reg, state_next;
  state_t            ret_reg, ret_next;
  logic [DUR_W-1:0]  beats_reg, beats_next;
  logic [FREQ_W-1:0] freq_lat_reg, freq_lat_next;
  logic [ADDR_W-1:0] idx_next;

  logic [FREQ_W-1:0] freq_next;
  logic              playing_next, strobe_next, end_next;

  rom_word_t rom_word;
  logic      beat, advance, idx_at_max, end_marker;

  song_rom #(
    .ADDR_W(ADDR_W),
    .SONG  (SONG)
  ) u_rom (
    .addr(note_idx),
    .word(rom_word)
  );

  // Two flops resynchronise the pin; the third holds the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= boton;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign toggle     = sync2_reg & ~sync3_reg;
  assign beat       = tick & ~toggle;
  assign idx_at_max = &note_idx;
  assign end_marker = (rom_word.dur == '0);
  assign advance    = beat && ((state_reg == PLAY && beats_reg == DUR_W'(1) && !GAP_EN)
                               || state_reg == GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ret_reg   <= IDLE;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ret_next      = ret_reg;
    beats_next    = beats_reg;
    idx_next      = note_idx;
    freq_lat_next = freq_lat_reg;
    case (state_reg)
      IDLE: begin
        if (toggle) begin
          idx_next   = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (!end_marker) begin
          freq_lat_next = rom_word.freq;
          beats_next    = rom_word.dur;
          state_next    = PLAY;
        end else if (LOOP && note_idx != '0) begin
          idx_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      PLAY: begin
        if (toggle) begin
          ret_next   = PLAY;
          state_next = PAUSE;
        end else if (beat) begin
          beats_next = beats_reg - DUR_W'(1);
          if (beats_reg == DUR_W'(1) && GAP_EN) state_next = GAP;
        end
      end
      GAP: begin
        if (toggle) begin
          ret_next   = GAP;
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (toggle) state_next = ret_reg;
      end
      default: state_next = IDLE;
    endcase
    // Moving past the last ROM address wraps the index and ends the song.
    if (advance) begin
      idx_next   = note_idx + ADDR_W'(1);
      state_next = (idx_at_max && !LOOP) ? IDLE : FETCH;
    end
  end

  always_comb begin
    freq_next    = freq_out;
    playing_next = is_active(state_next);
    strobe_next  = (state_reg == FETCH) && (state_next == PLAY);
    end_next     = ((state_reg == FETCH) && end_marker) || (advance && idx_at_max);
    case (state_next)
      IDLE:    freq_next = FREQ_OFF;
      FETCH:   freq_next = freq_out;
      PLAY:    freq_next = freq_lat_next;
      GAP:     freq_next = FREQ_SILENCE;
      PAUSE:   freq_next = FREQ_SILENCE;
      default: freq_next = FREQ_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out     <= FREQ_OFF;
      note_idx     <= '0;
      playing      <= 1'b0;
      note_strobe  <= 1'b0;
      song_end     <= 1'b0;
      beats_reg    <= '0;
      freq_lat_reg <= FREQ_OFF;
    end else begin
      freq_out     <= freq_next;
      note_idx     <= idx_next;
      playing      <= playing_next;
      note_strobe  <= strobe_next;
      song_end     <= end_next;
      beats_reg    <= beats_next;
      freq_lat_reg <= freq_lat_next;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: five parameter variants driven in lockstep,
// checked every cycle against a song-level model plus literal expectations.
module tb_note_sequencer;

  localparam int N = 5;
  localparam int M_IDLE = 0, M_FETCH = 1, M_PLAY = 2, M_GAP = 3, M_PAUSE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic boton = 1'b0;
  logic tick = 1'b0;

  logic [15:0] f_o [N];
  logic [5:0]  idx_o [N];
  logic        play_o [N];
  logic        stb_o [N];
  logic        end_o [N];
  logic [5:0]  idx_w0, idx_w1, idx_w2;
  logic [1:0]  idx_w3, idx_w4;

  assign idx_o[0] = idx_w0;
  assign idx_o[1] = idx_w1;
  assign idx_o[2] = idx_w2;
  assign idx_o[3] = {4'b0000, idx_w3};
  assign idx_o[4] = {4'b0000, idx_w4};

  initial forever #20 clk = ~clk;

  note_sequencer #(.ADDR_W(6), .LOOP(1'b0), .GAP_EN(1'b0), .SONG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .boton(boton), .tick(tick), .freq_out(f_o[0]),
    .note_idx(idx_w0), .playing(play_o[0]), .note_strobe(stb_o[0]), .song_end(end_o[0]));
  note_sequencer #(.ADDR_W(6), .LOOP(1'b0), .GAP_EN(1'b1), .SONG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .boton(boton), .tick(tick), .freq_out(f_o[1]),
    .note_idx(idx_w1), .playing(play_o[1]), .note_strobe(stb_o[1]), .song_end(end_o[1]));
  note_sequencer #(.ADDR_W(6), .LOOP(1'b1), .GAP_EN(1'b1), .SONG(0)) u2 (
    .clk(clk), .rst_n(rst_n), .boton(boton), .tick(tick), .freq_out(f_o[2]),
    .note_idx(idx_w2), .playing(play_o[2]), .note_strobe(stb_o[2]), .song_end(end_o[2]));
  note_sequencer #(.ADDR_W(2), .LOOP(1'b0), .GAP_EN(1'b0), .SONG(1)) u3 (
    .clk(clk), .rst_n(rst_n), .boton(boton), .tick(tick), .freq_out(f_o[3]),
    .note_idx(idx_w3), .playing(play_o[3]), .note_strobe(stb_o[3]), .song_end(end_o[3]));
  note_sequencer #(.ADDR_W(2), .LOOP(1'b1), .GAP_EN(1'b0), .SONG(1)) u4 (
    .clk(clk), .rst_n(rst_n), .boton(boton), .tick(tick), .freq_out(f_o[4]),
    .note_idx(idx_w4), .playing(play_o[4]), .note_strobe(stb_o[4]), .song_end(end_o[4]));

  int n_cmp = 0;
  int n_bad = 0;

  // Song-level model: what each variant should be doing after each clock.
  int loop_p [N] = '{0, 0, 1, 0, 1};
  int gap_p  [N] = '{0, 1, 1, 0, 0};
  int depth  [N] = '{64, 64, 64, 4, 4};
  int song_f [N][64];
  int song_d [N][64];
  int mode [N], ret [N], beats [N], midx [N], lat [N], mfreq [N];
  bit mstb [N], mend [N];
  bit h1, h2, h3;
  int stb_cnt [N], end_cnt [N];
  int log_f [N][$];

  task automatic model_reset();
    h1 = 0; h2 = 0; h3 = 0;
    for (int i = 0; i < N; i++) begin
      mode[i] = M_IDLE; ret[i] = M_IDLE; beats[i] = 0; midx[i] = 0;
      lat[i] = 0; mfreq[i] = 0; mstb[i] = 0; mend[i] = 0;
    end
  endtask

  task automatic next_note(input int i);
    if (midx[i] == depth[i] - 1) begin
      midx[i] = 0;
      mend[i] = 1;
      if (loop_p[i] != 0) mode[i] = M_FETCH;
      else begin mode[i] = M_IDLE; mfreq[i] = 0; end
    end else begin
      midx[i] = midx[i] + 1;
      mode[i] = M_FETCH;
    end
  endtask

  task automatic model_step();
    bit tg;
    tg = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = boton;
    for (int i = 0; i < N; i++) begin
      mstb[i] = 0; mend[i] = 0;
      case (mode[i])
        M_IDLE: if (tg) begin midx[i] = 0; mode[i] = M_FETCH; end
        M_FETCH: begin
          if (song_d[i][midx[i]] != 0) begin
            lat[i] = song_f[i][midx[i]]; beats[i] = song_d[i][midx[i]];
            mfreq[i] = lat[i]; mstb[i] = 1; mode[i] = M_PLAY;
          end else begin
            mend[i] = 1;
            if (loop_p[i] != 0 && midx[i] != 0) midx[i] = 0;
            else begin mode[i] = M_IDLE; mfreq[i] = 0; end
          end
        end
        M_PLAY: begin
          if (tg) begin ret[i] = M_PLAY; mode[i] = M_PAUSE; mfreq[i] = 1; end
          else if (tick) begin
            beats[i] = beats[i] - 1;
            if (beats[i] == 0) begin
              if (gap_p[i] != 0) begin mode[i] = M_GAP; mfreq[i] = 1; end
              else next_note(i);
            end
          end
        end
        M_GAP: begin
          if (tg) begin ret[i] = M_GAP; mode[i] = M_PAUSE; end
          else if (tick) next_note(i);
        end
        M_PAUSE: if (tg) begin mode[i] = ret[i]; mfreq[i] = (ret[i] == M_PLAY) ? lat[i] : 1; end
        default: ;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 64; a++) begin song_f[i][a] = 0; song_d[i][a] = 0; end
    for (int i = 0; i < 3; i++) begin
      song_f[i][0] = 440; song_d[i][0] = 2;
      song_f[i][1] = 494; song_d[i][1] = 1;
    end
    for (int i = 3; i < 5; i++) begin
      song_f[i][0] = 262; song_d[i][0] = 1;
      song_f[i][1] = 0;   song_d[i][1] = 1;
      song_f[i][2] = 330; song_d[i][2] = 2;
      song_f[i][3] = 1;   song_d[i][3] = 1;
    end
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all five variants against the model.
  initial begin
    for (int i = 0; i < N; i++) begin stb_cnt[i] = 0; end_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        bit exp_play;
        exp_play = (mode[i] == M_FETCH) || (mode[i] == M_PLAY) || (mode[i] == M_GAP);
        n_cmp++;
        if (f_o[i] !== 16'(mfreq[i]) || idx_o[i] !== 6'(midx[i]) || play_o[i] !== exp_play ||
            stb_o[i] !== mstb[i] || end_o[i] !== mend[i]) begin
          n_bad++;
          $display("FAIL model_u%0d @%0t: got freq=%0d idx=%0d play=%0b stb=%0b end=%0b, expected freq=%0d idx=%0d play=%0b stb=%0b end=%0b",
                   i, $time, f_o[i], idx_o[i], play_o[i], stb_o[i], end_o[i],
                   mfreq[i], midx[i], exp_play, mstb[i], mend[i]);
        end
        stb_cnt[i] += int'(stb_o[i]);
        end_cnt[i] += int'(end_o[i]);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d", name, act);
    end
  endtask

  task automatic press();
    boton = 1'b1;
    repeat (4) @(negedge clk);
    boton = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Times the tick to land on the same clock as the synchronised toggle.
  task automatic press_with_tick();
    boton = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    boton = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic beat();
    for (int i = 0; i < N; i++) log_f[i].push_back(int'(f_o[i]));
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int exp_a [N][7] = '{'{440, 440, 494, 0, 0, 0, 0},
                       '{440, 440, 1, 494, 1, 0, 0},
                       '{440, 440, 1, 494, 1, 440, 440},
                       '{262, 0, 330, 330, 1, 0, 0},
                       '{262, 0, 330, 330, 1, 262, 0}};
  int stb0, stb1, stb2, end0, end2, end3, end4;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lit("reset_freq", int'(f_o[0]), 0);
    lit("reset_idx", int'(idx_o[0]), 0);
    lit("reset_playing", int'(play_o[0]), 0);

    // Full song on every variant
    #1;
    stb0 = stb_cnt[0]; stb1 = stb_cnt[1]; stb2 = stb_cnt[2];
    end0 = end_cnt[0]; end2 = end_cnt[2]; end3 = end_cnt[3]; end4 = end_cnt[4];
    @(negedge clk);
    press();
    lit("start_freq_u0", int'(f_o[0]), 440);
    repeat (7) beat();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 7; k++)
        lit($sformatf("beat_u%0d_%0d", i, k), log_f[i][k], exp_a[i][k]);
    #1;
    lit("strobes_u0", stb_cnt[0] - stb0, 2);
    lit("strobes_u1", stb_cnt[1] - stb1, 2);
    lit("strobes_u2", stb_cnt[2] - stb2, 3);
    lit("song_end_u0", end_cnt[0] - end0, 1);
    lit("song_end_u2", end_cnt[2] - end2, 1);
    lit("song_end_wrap_u3", end_cnt[3] - end3, 1);
    lit("song_end_wrap_u4", end_cnt[4] - end4, 1);
    lit("idle_playing_u0", int'(play_o[0]), 0);
    lit("idle_freq_u3", int'(f_o[3]), 0);
    lit("loop_idx_u2", int'(idx_o[2]), 0);
    @(negedge clk);

    // Pause and resume
    do_reset();
    press();
    beat();
    press();
    lit("paused_freq_u0", int'(f_o[0]), 1);
    lit("paused_playing_u0", int'(play_o[0]), 0);
    repeat (5) beat();
    lit("paused_hold_u0", int'(f_o[0]), 1);
    lit("paused_idx_u0", int'(idx_o[0]), 0);
    press();
    lit("resumed_freq_u0", int'(f_o[0]), 440);
    beat();
    lit("after_resume_u0", int'(f_o[0]), 494);

    // Toggle and tick on the same clock
    do_reset();
    press();
    press_with_tick();
    lit("tt_paused_u0", int'(f_o[0]), 1);
    press();
    beat();
    lit("tt_beat1_u0", int'(f_o[0]), 440);
    beat();
    lit("tt_beat2_u0", int'(f_o[0]), 494);

    // Asynchronous reset mid-note
    do_reset();
    press();
    beat();
    beat();
    lit("pre_reset_u0", int'(f_o[0]), 494);
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    lit("async_freq_u0", int'(f_o[0]), 0);
    lit("async_idx_u0", int'(idx_o[0]), 0);
    lit("async_playing_u0", int'(play_o[0]), 0);
    lit("async_strobe_u0", int'(stb_o[0]), 0);
    lit("async_end_u0", int'(end_o[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    beat();
    beat();
    lit("post_reset_freq_u0", int'(f_o[0]), 0);
    lit("post_reset_playing_u0", int'(play_o[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
